seg7_scan_driver: RTL
=====================

// Module: seg7_scan_driver
// PURPOSE
//  Time-multiplexed N-digit seven-segment display driver for the microwave front panel.
//  Latches BCD/hex digit values, scans one digit at a time over shared segment lines,
//  and optionally applies leading-zero suppression, per-digit decimal points and blinking
//  (e.g. flashing 00:00 at end of cook). Sits between the timer/FSM level and the board pins.
// PARAMETERS
//  NUM_DIGITS  4     digits scanned (>=2); digit 0 = least significant (seconds ones)
//  SCAN_DIV    1000  clk cycles each digit is held active (>=2)
//  BLINK_DIV   250   full scan rounds per blink half-period (>=1)
//  HEX_MODE    0     1: codes 10-15 show A,b,C,d,E,F; 0: codes 10-15 show '0'
// PORTS
//  clk        in   1             system clock, rising edge
//  rst_n      in   1             synchronous reset, active low
//  digits_in  in   4*NUM_DIGITS  digit codes, digit k at [4k+3:4k]
//  dp_in      in   NUM_DIGITS    decimal point request per digit, 1 = lit
//  load       in   1             1-cycle strobe: capture digits_in and dp_in
//  lz_en      in   1             1 = leading-zero suppression enabled
//  blink_en   in   1             1 = whole display blinks
//  seg_out    out  7             segments {a,b,c,d,e,f,g}, bit6 = a; active low
//  dp_out     out  1             decimal point, active low
//  an_out     out  NUM_DIGITS    digit enables, one-hot, active low
// BEHAVIOUR
//  - Reset: prescaler=0, digit index=0, blink phase=ON, latched digits=0, latched dp=0;
//    seg_out=7'b111_1111, dp_out=1, an_out=all 1. Reset wins over load in the same cycle.
//  - Reset mid-scan: outputs go dark on the next edge; the scan restarts at digit 0.
//  - Glyphs (active low, a..g): 0=000_0001 1=100_1111 2=001_0010 3=000_0110 4=100_1100
//    5=010_0100 6=010_0000 7=000_1111 8=000_0000 9=000_0100; blank=111_1111.
//  - load=1: regs capture on that edge; the glyph is visible from the next output update.
//    Without load, the display holds the latched values regardless of digits_in.
//  - Prescaler counts 0..SCAN_DIV-1 and wraps. At the terminal count the index advances
//    k -> k+1, and from NUM_DIGITS-1 it wraps to 0.
//  - Outputs are registered: one-cycle latency from index/latch change to seg/an/dp.
//    an_out has exactly one 0 (bit = index), except when blanked. No glitch cycle with 2 zeros.
//  - Leading-zero suppression (lz_en=1): a digit k is blank if its code and every code
//    above it are 0. Digit 0 is never blanked. The blank applies to seg only; dp is unaffected.
//  - Blink: the round counter increments when the index wraps to 0. After BLINK_DIV rounds
//    the phase toggles. blink_en=1 with phase OFF: an_out=all 1, seg=blank, dp_out=1.
//    blink_en=0: the phase keeps running but is ignored.
//  - Codes 10-15: glyph per HEX_MODE. HEX_MODE=0 matches legacy behaviour ('0').
//  - Counter widths: $clog2 of each range. No overflow outside the stated wraps.
// STRUCTURE
//  - Package seg7_pkg: glyph localparams SEG_0..SEG_9, SEG_A..SEG_F, SEG_BLANK.
//  - Sub-module seg7_decode (combinational): 4-bit code + hex_mode -> 7-bit glyph.
//    It is instantiated once, on the muxed digit.
//  - Top: load regs, prescaler, index counter, round/blink counter, output regs.
// TESTING  (NUM_DIGITS=4, SCAN_DIV=4, BLINK_DIV=2 unless noted)
//  - Reset: hold rst_n=0 for 3 cycles -> an=1111, seg=111_1111, dp=1.
//    After release, an=1110 for 4 cycles, then 1101, 1011, 0111, 1110 (wrap).
//  - load digits_in=16'h0305: digit0 seg=010_0100, digit1 seg=000_0001.
//    digit2 seg=000_0110, digit3 seg=000_0001.
//  - Same load with lz_en=1: digit3 blank (111_1111), digits 2..0 lit.
//    Load 16'h0000: only digit0 is lit, showing '0'.
//  - blink_en=1: dark for 2 full rounds (32 cycles) and lit for 2 rounds, repeating.
//    Deasserting blink_en mid-dark restores the output on the next update.
//  - HEX_MODE=0 then 1, code 4'hB on digit0 -> 000_0001, then 110_0000 ('b').
//    Sweep all 16 codes against the seg7_pkg table.
//  - Simultaneous rst_n=0 and load=1 -> latched digits stay 0.
//    A load on the prescaler terminal-count cycle -> the new glyph appears on the new digit.
//    dp_in=4'b0100 -> dp_out=0 only while an=1011.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared glyph table for the seven-segment front-panel driver.
// Segment order {a,b,c,d,e,f,g}, bit6 = a, active low.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b000_0001;
    localparam logic [6:0] SEG_1     = 7'b100_1111;
    localparam logic [6:0] SEG_2     = 7'b001_0010;
    localparam logic [6:0] SEG_3     = 7'b000_0110;
    localparam logic [6:0] SEG_4     = 7'b100_1100;
    localparam logic [6:0] SEG_5     = 7'b010_0100;
    localparam logic [6:0] SEG_6     = 7'b010_0000;
    localparam logic [6:0] SEG_7     = 7'b000_1111;
    localparam logic [6:0] SEG_8     = 7'b000_0000;
    localparam logic [6:0] SEG_9     = 7'b000_0100;
    localparam logic [6:0] SEG_A     = 7'b000_1000;
    localparam logic [6:0] SEG_B     = 7'b110_0000;
    localparam logic [6:0] SEG_C     = 7'b011_0001;
    localparam logic [6:0] SEG_D     = 7'b100_0010;
    localparam logic [6:0] SEG_E     = 7'b011_0000;
    localparam logic [6:0] SEG_F     = 7'b011_1000;
    localparam logic [6:0] SEG_BLANK = 7'b111_1111;

endpackage

// File: rtl/seg7_decode.sv
// Purpose: 4-bit digit code to active-low seven-segment glyph.
// Latency: combinational. Backpressure: none.
// Codes 10-15 fall back to '0' unless hex_mode selects the A..F letters.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] code,
    input  logic       hex_mode,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = SEG_BLANK;
        case (code)
            4'h0: glyph = SEG_0;
            4'h1: glyph = SEG_1;
            4'h2: glyph = SEG_2;
            4'h3: glyph = SEG_3;
            4'h4: glyph = SEG_4;
            4'h5: glyph = SEG_5;
            4'h6: glyph = SEG_6;
            4'h7: glyph = SEG_7;
            4'h8: glyph = SEG_8;
            4'h9: glyph = SEG_9;
            4'hA: glyph = hex_mode ? SEG_A : SEG_0;
            4'hB: glyph = hex_mode ? SEG_B : SEG_0;
            4'hC: glyph = hex_mode ? SEG_C : SEG_0;
            4'hD: glyph = hex_mode ? SEG_D : SEG_0;
            4'hE: glyph = hex_mode ? SEG_E : SEG_0;
            4'hF: glyph = hex_mode ? SEG_F : SEG_0;
            default: glyph = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Purpose: time-multiplexed N-digit seven-segment driver with leading-zero blanking and blink.
// Latency: one cycle from index/latch change to seg_out/an_out/dp_out (all registered).
// Backpressure: none; load is a 1-cycle strobe that is always accepted.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int BLINK_DIV  = 250,
    parameter int HEX_MODE   = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [4*NUM_DIGITS-1:0]   digits_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic                      load,
    input  logic                      lz_en,
    input  logic                      blink_en,
    output logic [6:0]                seg_out,
    output logic                      dp_out,
    output logic [NUM_DIGITS-1:0]     an_out
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int RW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [NUM_DIGITS-1:0][3:0] dig_q, dig_d;
    logic [NUM_DIGITS-1:0]      dpl_q, dpl_d;
    logic [PW-1:0]              presc_q, presc_d;
    logic [IW-1:0]              idx_q, idx_d;
    logic [RW-1:0]              round_q, round_d;
    logic                       phase_q, phase_d;
    logic [6:0]                 seg_q, seg_d;
    logic                       dp_q, dp_d;
    logic [NUM_DIGITS-1:0]      an_q, an_d;

    logic                       presc_tc;
    logic                       idx_wrap;
    logic [3:0]                 cur_code;
    logic [6:0]                 cur_glyph;
    logic [NUM_DIGITS-1:0]      lz_blank;
    logic                       upper_zero;

    assign cur_code = dig_q[idx_q];

    seg7_decode u_decode (
        .code     (cur_code),
        .hex_mode (HEX_MODE != 0),
        .glyph    (cur_glyph)
    );

    // Scan timing: prescaler, digit index, and round counter driving the blink phase.
    always_comb begin
        presc_tc = (presc_q == PW'(SCAN_DIV - 1));
        idx_wrap = presc_tc && (idx_q == IW'(NUM_DIGITS - 1));

        presc_d = presc_tc ? '0 : presc_q + PW'(1);

        idx_d = idx_q;
        if (presc_tc) begin
            idx_d = idx_wrap ? '0 : idx_q + IW'(1);
        end

        round_d = round_q;
        phase_d = phase_q;
        if (idx_wrap) begin
            if (round_q == RW'(BLINK_DIV - 1)) begin
                round_d = '0;
                phase_d = ~phase_q;
            end else begin
                round_d = round_q + RW'(1);
            end
        end

        dig_d = load ? digits_in : dig_q;
        dpl_d = load ? dp_in : dpl_q;
    end

    // A digit is suppressed when it and every more-significant digit are zero; digit 0 always shows.
    always_comb begin
        upper_zero = 1'b1;
        lz_blank   = '0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            upper_zero  = upper_zero && (dig_q[k] == 4'd0);
            lz_blank[k] = lz_en && upper_zero;
        end
    end

    always_comb begin
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        an_d  = '1;
        if (!(blink_en && !phase_q)) begin
            an_d  = ~(NUM_DIGITS'(1) << idx_q);
            seg_d = lz_blank[idx_q] ? SEG_BLANK : cur_glyph;
            dp_d  = ~dpl_q[idx_q];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dig_q   <= '0;
            dpl_q   <= '0;
            presc_q <= '0;
            idx_q   <= '0;
            round_q <= '0;
            phase_q <= 1'b1;
            seg_q   <= SEG_BLANK;
            dp_q    <= 1'b1;
            an_q    <= '1;
        end else begin
            dig_q   <= dig_d;
            dpl_q   <= dpl_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            round_q <= round_d;
            phase_q <= phase_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            an_q    <= an_d;
        end
    end

    assign seg_out = seg_q;
    assign dp_out  = dp_q;
    assign an_out  = an_q;

endmodule
